simon_game_ctrl: RTL

Top-level game sequencer for the Simon Says design. Generates a pseudo-random colour sequence that grows by one colour per round and plays it out on the LED outputs. It then arms and enables the player-input capture block (WAIT_STATE) and compares the captured 2-bit-per-colour sequence against the target. On the result it advances the level, declares a win, or ends the game.

---
 rtl/simon_pkg.sv | 25 ++
 rtl/simon_game_ctrl_if.sv | 19 +
 rtl/simon_lfsr.sv | 26 ++
 rtl/simon_game_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared types and constants for the Simon Says sequencer.
//   state_e   - top-level FSM state encoding (4-bit, exported on debug port)
//   COLOUR_W  - bits per colour in target / captured sequences
//   LFSR_TAPS - feedback tap mask for the 16-bit Fibonacci LFSR
package simon_pkg;

  localparam int COLOUR_W = 2;

  // Feedback = l[15]^l[13]^l[12]^l[10]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GEN      = 4'd1,
    SHOW_OFF = 4'd2,
    SHOW_ON  = 4'd3,
    ARM      = 4'd4,
    COLLECT  = 4'd5,
    CHECK    = 4'd6,
    PASS     = 4'd7,
    FAIL     = 4'd8,
    WIN      = 4'd9
  } state_e;

endpackage

// File: rtl/simon_game_ctrl_if.sv
// simon_game_ctrl_if: link between the game sequencer and the player-input
// capture block (WAIT_STATE).
//   wait_rst      - one-cycle clear pulse to the capture block
//   wait_en       - capture enable
//   seq_len       - number of colours the capture block should collect
//   complete_wait - capture block has collected seq_len colours
//   sequence_val  - captured colours, colour i at bits [2i+1:2i]
interface simon_game_ctrl_if;
  logic        wait_rst;
  logic        wait_en;
  logic [3:0]  seq_len;
  logic        complete_wait;
  logic [31:0] sequence_val;

  modport master (output wait_rst, wait_en, seq_len,
                  input  complete_wait, sequence_val);
  modport slave  (input  wait_rst, wait_en, seq_len,
                  output complete_wait, sequence_val);
endinterface

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running 16-bit Fibonacci LFSR, shifts left every clock.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, loads SEED
//   rnd_o  - low OUT_W bits of the current LFSR state
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign rnd_o  = lfsr_q[OUT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: Simon Says game sequencer. Grows a random colour sequence
// by one colour per round, plays it on the LED, arms the capture block,
// compares the captured answer and advances / wins / ends the game.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   start_i       - new game request (honoured in IDLE, FAIL, WIN)
//   wif           - capture-block link (master side)
//   led_on_o      - playback LED active
//   led_colour_o  - colour being shown, 0 while dark
//   level_o       - current level (mirrors seq_len)
//   game_over_o   - high while in FAIL
//   game_win_o    - high while in WIN
//   state_o       - FSM state for debug
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int          MAX_LEN        = 15,
  parameter int          SHOW_CYCLES    = 8,
  parameter int          GAP_CYCLES     = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  simon_game_ctrl_if.master    wif,
  output logic                 led_on_o,
  output logic [COLOUR_W-1:0]  led_colour_o,
  output logic [3:0]           level_o,
  output logic                 game_over_o,
  output logic                 game_win_o,
  output logic [3:0]           state_o
);

  localparam int CMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [3:0]          level_q, level_d;
  logic [3:0]          idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [31:0]         target_q, target_d;
  logic [31:0]         cmp_mask;
  logic [COLOUR_W-1:0] rnd;

  simon_lfsr #(.SEED(LFSR_SEED), .OUT_W(COLOUR_W)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rnd_o (rnd)
  );

  // Only the first 2*level bits of the answer are meaningful.
  assign cmp_mask    = (32'd1 << {level_q, 1'b0}) - 32'd1;
  assign wif.seq_len = level_q;
  assign level_o     = level_q;
  assign state_o     = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      level_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    target_d     = target_q;
    led_on_o     = 1'b0;
    led_colour_o = '0;
    wif.wait_rst = 1'b0;
    wif.wait_en  = 1'b0;
    game_over_o  = 1'b0;
    game_win_o   = 1'b0;

    case (state_q)
      IDLE, FAIL, WIN: begin
        game_over_o = (state_q == FAIL);
        game_win_o  = (state_q == WIN);
        if (start_i) begin
          level_d  = 4'd1;
          target_d = '0;
          state_d  = GEN;
        end
      end
      GEN: begin
        // Append one new colour at the tail of the sequence.
        target_d[{level_q - 4'd1, 1'b0} +: COLOUR_W] = rnd;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SHOW_ON;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW_ON: begin
        led_on_o     = 1'b1;
        led_colour_o = target_q[{idx_q, 1'b0} +: COLOUR_W];
        if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
          cnt_d = '0;
          if (idx_q == level_q - 4'd1) begin
            state_d = ARM;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHOW_OFF;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ARM: begin
        wif.wait_rst = 1'b1;
        tmo_d        = '0;
        state_d      = COLLECT;
      end
      COLLECT: begin
        wif.wait_en = 1'b1;
        // A completed capture wins over a timeout landing in the same cycle.
        if (wif.complete_wait)                    state_d = CHECK;
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = FAIL;
        else                                      tmo_d   = tmo_q + TW'(1);
      end
      CHECK: begin
        if (((wif.sequence_val ^ target_q) & cmp_mask) == 32'd0) state_d = PASS;
        else                                                     state_d = FAIL;
      end
      PASS: begin
        if (level_q == 4'(MAX_LEN)) begin
          state_d = WIN;
        end else begin
          level_d = level_q + 4'd1;
          state_d = GEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
